spi_slave_gen2: RTL

SPI_SLAVE_GEN2 -- requirements
Module: spi_slave_gen2

---
 rtl/spi_slave_gen2_pkg.sv | 25 ++
 rtl/spi_slave_gen2_if.sv | 24 ++
 rtl/spi_slave_gen2_shift_reg.sv | 28 ++
 rtl/spi_slave_gen2.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/spi_slave_gen2_pkg.sv
// Shared types and constants for the gen2 SPI slave: FSM states, command
// encodings and the counter-width helper.
package spi_slave_gen2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA,
    READ_WAIT,
    TX
  } spi_gen2_state_e;

  // Two-bit command that leads every received word; bit 1 is the read flag.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_slave_gen2_if.sv
// Serial pins plus the parallel rx/tx side of the gen2 SPI slave.
interface spi_slave_gen2_if #(
  parameter int ADDR_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [ADDR_W+1:0] rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] tx_data;
  logic              tx_valid;
  logic              abort;
  logic              busy;

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, abort, busy
  );

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, abort, busy
  );
endinterface

// File: rtl/spi_slave_gen2_shift_reg.sv
// MSB-first shift register with parallel load; load wins over shift.
module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             so
);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], si};
    end
  end

  assign so = q[WIDTH-1];

endmodule

// File: rtl/spi_slave_gen2.sv
// Gen2 SPI slave: frames {cmd, payload} words from MOSI and returns read
// data on MISO after a handshake with the RAM side, with abort/timeout.
module spi_slave_gen2
  import spi_slave_gen2_pkg::*;
#(
  parameter int   ADDR_W     = 8,
  parameter int   TX_TIMEOUT = 16,
  parameter logic MISO_IDLE  = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  spi_slave_gen2_if.slave bus
);

  localparam int FRAME_W = ADDR_W + 2;
  localparam int BIT_CW  = cnt_w(FRAME_W);
  localparam int TMO_CW  = cnt_w(TX_TIMEOUT);

  localparam logic [BIT_CW-1:0] BIT_ONE   = BIT_CW'(1);
  localparam logic [BIT_CW-1:0] FRAME_CNT = BIT_CW'(FRAME_W);
  localparam logic [BIT_CW-1:0] TX_CNT    = BIT_CW'(ADDR_W - 1);
  localparam logic [TMO_CW-1:0] TMO_ONE   = TMO_CW'(1);
  localparam logic [TMO_CW-1:0] TMO_LOAD  = TMO_CW'(TX_TIMEOUT);

  spi_gen2_state_e   state_q, state_d;
  logic [BIT_CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [TMO_CW-1:0] tmo_q, tmo_d;
  logic              rd_loaded_q, rd_loaded_d;
  logic              rx_valid_q, rx_valid_d;
  logic              abort_q, abort_d;
  logic              miso_q, miso_d;
  logic              rx_shift, tx_load, tx_shift;
  logic              tx_so;
  logic              rx_so_unused;
  logic [ADDR_W-1:0] tx_par_unused;

  spi_shift_reg #(.WIDTH(FRAME_W)) u_rx_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val ('0),
    .shift_en (rx_shift),
    .si       (bus.MOSI),
    .q        (bus.rx_data),
    .so       (rx_so_unused)
  );

  // The MSB goes straight to MISO at capture, so the register keeps the rest.
  spi_shift_reg #(.WIDTH(ADDR_W)) u_tx_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tx_load),
    .load_val ({bus.tx_data[ADDR_W-2:0], 1'b0}),
    .shift_en (tx_shift),
    .si       (1'b0),
    .q        (tx_par_unused),
    .so       (tx_so)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      rd_loaded_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      abort_q     <= 1'b0;
      miso_q      <= MISO_IDLE;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      rd_loaded_q <= rd_loaded_d;
      rx_valid_q  <= rx_valid_d;
      abort_q     <= abort_d;
      miso_q      <= miso_d;
    end
  end

  // NOTE: defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tmo_d       = tmo_q;
    rd_loaded_d = rd_loaded_q;
    rx_valid_d  = 1'b0;
    abort_d     = 1'b0;
    miso_d      = MISO_IDLE;
    rx_shift    = 1'b0;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.SS_n) state_d = CHK_CMD;
      end

      CHK_CMD: begin
        if (bus.SS_n) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else begin
          bit_cnt_d = FRAME_CNT;
          if (bus.MOSI != CMD_RD_ADDR[1]) state_d = WRITE;
          else                            state_d = rd_loaded_q ? READ_DATA : READ_ADD;
        end
      end

      WRITE, READ_ADD, READ_DATA: begin
        if (bit_cnt_q == '0) begin
          // Word already delivered: ignore MOSI until the frame closes.
          if (bus.SS_n) state_d = IDLE;
        end else if (bus.SS_n && bit_cnt_q != BIT_ONE) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else begin
          rx_shift  = 1'b1;
          bit_cnt_d = bit_cnt_q - BIT_ONE;
          if (bit_cnt_q == BIT_ONE) begin
            rx_valid_d = 1'b1;
            if (state_q == READ_ADD) rd_loaded_d = 1'b1;
            if (state_q == READ_DATA) begin
              state_d = READ_WAIT;
              tmo_d   = TMO_LOAD;
            end
            if (bus.SS_n) state_d = IDLE;
          end
        end
      end

      READ_WAIT: begin
        if (bus.SS_n) begin
          state_d = IDLE;
          abort_d = (tmo_q != '0);
        end else if (tmo_q != '0) begin
          if (bus.tx_valid) begin
            state_d   = TX;
            tx_load   = 1'b1;
            miso_d    = bus.tx_data[ADDR_W-1];
            bit_cnt_d = TX_CNT;
          end else begin
            tmo_d = tmo_q - TMO_ONE;
            if (tmo_q == TMO_ONE) begin
              abort_d     = 1'b1;
              rd_loaded_d = 1'b0;
            end
          end
        end
      end

      TX: begin
        if (bit_cnt_q != '0) begin
          if (bus.SS_n) begin
            state_d = IDLE;
            abort_d = 1'b1;
          end else begin
            miso_d    = tx_so;
            tx_shift  = 1'b1;
            bit_cnt_d = bit_cnt_q - BIT_ONE;
          end
        end else begin
          rd_loaded_d = 1'b0;
          if (bus.SS_n) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.abort    = abort_q;
  assign bus.busy     = (state_q != IDLE);

endmodule
